// File: rtl/load_store_unit.sv
// Load/store sequencer in front of the byte-lane BRAM: request handshake, range check, sign/zero extension.
// Optional: define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses on the error path.
module load_store_unit #(
  parameter int MEM_BYTES = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] memory_address,
  output logic [31:0] memory_in,
  output logic [1:0]  memory_size,
  output logic        memory_write_enable,
  input  logic [31:0] memory_out
);

  // state   | meaning
  // S_IDLE  | ready for a request
  // S_ISSUE | address/data presented; write strobe cycle for stores
  // S_DATA  | memory read data valid; capture extended load data
  // S_RESP  | response presented until the core takes it
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DATA, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic [31:0] r_wdata;
  logic        r_write;
  logic        r_unsigned;
  logic        r_resp_valid;
  logic        r_resp_error;
  logic [31:0] r_resp_rdata;

  logic        w_accept;
  logic [32:0] w_span;
  logic        w_range_err;
  logic        w_misalign;
  logic        w_reject;
  logic [31:0] w_ext;

  assign w_accept = req_valid & (r_state == S_IDLE);

  always_comb begin
    w_span = 33'd4;
    case (req_size)
      2'b00:   w_span = 33'd1;
      2'b01:   w_span = 33'd2;
      default: w_span = 33'd4;
    endcase
  end

  // 33-bit sum keeps addresses near 0xFFFFFFFF from wrapping into range
  assign w_range_err = (({1'b0, req_addr} + w_span) > 33'(MEM_BYTES));

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    w_misalign = 1'b0;
    case (req_size)
      2'b00:   w_misalign = 1'b0;
      2'b01:   w_misalign = req_addr[0];
      default: w_misalign = (req_addr[1:0] != 2'b00);
    endcase
  end
`else
  assign w_misalign = 1'b0;
`endif

  assign w_reject = w_range_err | w_misalign;

  always_comb begin
    w_ext = memory_out;
    case (r_size)
      2'b00:   w_ext = {{24{~r_unsigned & memory_out[7]}}, memory_out[7:0]};
      2'b01:   w_ext = {{16{~r_unsigned & memory_out[15]}}, memory_out[15:0]};
      default: w_ext = memory_out;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_reject ? S_RESP : S_ISSUE;
      end
      S_ISSUE: w_next = S_DATA;
      S_DATA:  w_next = S_RESP;
      S_RESP: begin
        if (r_resp_valid && resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_size       <= '0;
      r_wdata      <= '0;
      r_write      <= 1'b0;
      r_unsigned   <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr       <= req_addr;
            r_size       <= req_size;
            r_wdata      <= req_wdata;
            r_write      <= req_write;
            r_unsigned   <= req_unsigned;
            r_resp_error <= w_reject;
            r_resp_rdata <= '0;
          end
        end
        S_DATA: begin
          r_resp_rdata <= r_write ? 32'd0 : w_ext;
        end
        S_RESP: begin
          // valid rises one edge after entering RESP; rdata/error untouched here
          if (r_resp_valid && resp_ready) r_resp_valid <= 1'b0;
          else                            r_resp_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready           = (r_state == S_IDLE);
  assign resp_valid          = r_resp_valid;
  assign resp_rdata          = r_resp_rdata;
  assign resp_error          = r_resp_error;
  assign memory_address      = r_addr;
  assign memory_in           = r_wdata;
  assign memory_size         = r_size;
  assign memory_write_enable = (r_state == S_ISSUE) & r_write;

endmodule
